spgd_perturb_seq: RTL and testbench



---
 rtl/spgd_pkg.sv | 17 +
 rtl/spgd_lfsr16.sv | 32 +++
 rtl/spgd_perturb_seq.sv | 165 ++++++++++++++++
 tb/tb_spgd_perturb_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD control path: sequencer state encoding and
// the 16-bit perturbation LFSR constants.
package spgd_pkg;

    localparam int          IN_WIDTH_DEF  = 14;
    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/spgd_lfsr16.sv
// 16-bit Fibonacci LFSR with step enable; shifts right, feedback enters at bit 15.
module spgd_lfsr16
    import spgd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {^(state_q & LFSR_TAPS), state_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/spgd_perturb_seq.sv
// SPGD perturbation sequencer: sweeps every channel, presents u +/- s*step to the
// external saturating adder and forwards each clamped result to the DAC writer.
module spgd_perturb_seq
    import spgd_pkg::*;
#(
    parameter int          IN_WIDTH  = IN_WIDTH_DEF,
    parameter int          NUM_CH    = 8,
    parameter int          CH_W      = 3,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                neg_phase,
    input  logic [IN_WIDTH-1:0] step,
    input  logic                base_we,
    input  logic [CH_W-1:0]     base_addr,
    input  logic [IN_WIDTH-1:0] base_data,
    output logic [IN_WIDTH-1:0] sat_a,
    output logic [IN_WIDTH-1:0] sat_b,
    output logic                sat_sub,
    input  logic [IN_WIDTH-1:0] sat_actual,
    output logic                dac_valid,
    input  logic                dac_ready,
    output logic [CH_W-1:0]     dac_ch,
    output logic [IN_WIDTH-1:0] dac_data,
    output logic [NUM_CH-1:0]   sign_bits,
    output logic                busy,
    output logic                done
);

    localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [IN_WIDTH-1:0] STEP_MASK = {1'b0, {(IN_WIDTH-1){1'b1}}};

    state_e              state_q,     state_d;
    logic [CH_W-1:0]     ch_q,        ch_d;
    logic [IN_WIDTH-1:0] step_q,      step_d;
    logic                neg_q,       neg_d;
    logic [IN_WIDTH-1:0] base_q [NUM_CH];
    logic [IN_WIDTH-1:0] base_d [NUM_CH];
    logic [NUM_CH-1:0]   sign_q,      sign_d;
    logic                dac_valid_q, dac_valid_d;
    logic [CH_W-1:0]     dac_ch_q,    dac_ch_d;
    logic [IN_WIDTH-1:0] dac_data_q,  dac_data_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                lfsr_en;
    logic [15:0]         lfsr_state;

    spgd_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        step_d      = step_q;
        neg_d       = neg_q;
        base_d      = base_q;
        sign_d      = sign_q;
        dac_valid_d = dac_valid_q;
        dac_ch_d    = dac_ch_q;
        dac_data_d  = dac_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lfsr_en     = 1'b0;
        sat_a       = '0;
        sat_b       = '0;
        sat_sub     = 1'b0;

        case (state_q)
            IDLE: begin
                if (base_we && (32'(base_addr) < NUM_CH)) begin
                    base_d[base_addr] = base_data;
                end
                if (start) begin
                    step_d  = step;
                    neg_d   = neg_phase;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sat_a = base_q[ch_q];
                sat_b = step_q & STEP_MASK;
                if (!neg_q) begin
                    sat_sub      = lfsr_state[0];
                    sign_d[ch_q] = lfsr_state[0];
                    lfsr_en      = 1'b1;
                end else begin
                    sat_sub = ~sign_q[ch_q];
                end
                dac_data_d  = sat_actual;
                dac_ch_d    = ch_q;
                dac_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                // sign_q[ch] already holds this channel's draw, so the operands stay put
                sat_a   = base_q[ch_q];
                sat_b   = step_q & STEP_MASK;
                sat_sub = sign_q[ch_q] ^ neg_q;
                if (dac_ready) begin
                    dac_valid_d = 1'b0;
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            step_q      <= '0;
            neg_q       <= 1'b0;
            base_q      <= '{default: '0};
            sign_q      <= '0;
            dac_valid_q <= 1'b0;
            dac_ch_q    <= '0;
            dac_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            step_q      <= step_d;
            neg_q       <= neg_d;
            base_q      <= base_d;
            sign_q      <= sign_d;
            dac_valid_q <= dac_valid_d;
            dac_ch_q    <= dac_ch_d;
            dac_data_q  <= dac_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // A zero LFSR state would lock every future sign to zero
    assert property (@(posedge clk) disable iff (rst) lfsr_state != 16'h0000);

    assign dac_valid = dac_valid_q;
    assign dac_ch    = dac_ch_q;
    assign dac_data  = dac_data_q;
    assign sign_bits = sign_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spgd_perturb_seq.sv
// Scoreboard bench for spgd_perturb_seq with a behavioural sweep model and a
// saturating adder model closing the sat_* loop.
module tb_spgd_perturb_seq;

    localparam int W = 14;
    localparam int N = 8;
    localparam int SEED = 16'hACE1;
    localparam int MAXV = (1 << (W - 1)) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          neg_phase = 1'b0;
    logic [W-1:0]  step = '0;
    logic          base_we = 1'b0;
    logic [2:0]    base_addr = '0;
    logic [W-1:0]  base_data = '0;
    logic [W-1:0]  sat_a, sat_b, sat_actual;
    logic          sat_sub;
    logic          dac_valid;
    logic          dac_ready = 1'b1;
    logic [2:0]    dac_ch;
    logic [W-1:0]  dac_data;
    logic [N-1:0]  sign_bits;
    logic          busy, done;

    spgd_perturb_seq dut (
        .clk(clk), .rst(rst), .start(start), .neg_phase(neg_phase), .step(step),
        .base_we(base_we), .base_addr(base_addr), .base_data(base_data),
        .sat_a(sat_a), .sat_b(sat_b), .sat_sub(sat_sub), .sat_actual(sat_actual),
        .dac_valid(dac_valid), .dac_ready(dac_ready), .dac_ch(dac_ch), .dac_data(dac_data),
        .sign_bits(sign_bits), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    // Downstream saturating adder: result clamped to [0, 2^(W-1)-1]
    function automatic logic [W-1:0] sat_fn(input int a, input int b, input bit sub);
        int r;
        r = sub ? (a - b) : (a + b);
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
        return W'(r);
    endfunction

    always_comb sat_actual = sat_fn(int'(sat_a), int'(sat_b), sat_sub);

    function automatic int lfsr_step(input int s);
        int fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return ((s >> 1) | (fb << 15)) & 16'hFFFF;
    endfunction

    typedef struct {
        logic [2:0]   ch;
        logic [W-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] mbase [N];
    logic [N-1:0] msign;
    int           mlfsr;
    logic [N-1:0] first_signs;

    bit stall_en = 0;
    bit rand_ready = 0;
    int stall_ch = 0;
    int stall_len = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mbase[i] = '0;
        msign = '0;
        mlfsr = SEED;
        exp_q.delete();
    endtask

    task automatic model_sweep(input bit neg, input logic [W-1:0] stp);
        beat_t b;
        bit    sub;
        for (int c = 0; c < N; c++) begin
            if (!neg) begin
                sub      = mlfsr[0];
                msign[c] = sub;
                mlfsr    = lfsr_step(mlfsr);
            end else begin
                sub = !msign[c];
            end
            b.ch   = 3'(c);
            b.data = sat_fn(int'(mbase[c]), int'(stp) & MAXV, sub);
            exp_q.push_back(b);
        end
    endtask

    task automatic write_base(input int addr, input logic [W-1:0] val);
        base_we   = 1'b1;
        base_addr = 3'(addr);
        base_data = val;
        mbase[addr] = val;
        tick();
        base_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sat_a"}, sat_a, 0);
        check({tag, "_sat_b"}, sat_b, 0);
        check({tag, "_sat_sub"}, sat_sub, 0);
        check({tag, "_dac_valid"}, dac_valid, 0);
        check({tag, "_dac_ch"}, dac_ch, 0);
        check({tag, "_dac_data"}, dac_data, 0);
        check({tag, "_sign_bits"}, sign_bits, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic sweep(input bit neg, input logic [W-1:0] stp, input int exp_cyc,
                         input bit poke, input bit wr0, input logic [W-1:0] wr0_data);
        int cyc;
        if (wr0) mbase[0] = wr0_data;
        model_sweep(neg, stp);
        start     = 1'b1;
        neg_phase = neg;
        step      = stp;
        if (wr0) begin
            base_we   = 1'b1;
            base_addr = 3'd0;
            base_data = wr0_data;
        end
        tick();
        start   = 1'b0;
        base_we = 1'b0;
        cyc     = 1;
        check("busy_after_start", busy, 1);
        while (!done && cyc < 1000) begin
            if (exp_cyc == 2 * N + 2 && cyc == 2) check("first_valid_latency", dac_valid, 1);
            if (poke && cyc == 5) begin
                start     = 1'b1;
                base_we   = 1'b1;
                base_addr = 3'd1;
                base_data = W'($urandom);
            end
            tick();
            start   = 1'b0;
            base_we = 1'b0;
            cyc++;
        end
        check("done_seen", done, 1);
        if (exp_cyc != 0) check("sweep_cycles", cyc, exp_cyc);
        check("busy_at_done", busy, 0);
        check("sign_bits", sign_bits, msign);
        check("queue_drained", exp_q.size(), 0);
        tick();
        check("done_pulse_width", done, 0);
        check("no_second_sweep", busy, 0);
    endtask

    // DAC-side ready generation
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en && dac_valid && int'(dac_ch) == stall_ch && stall_cnt < stall_len) begin
            dac_ready = 1'b0;
            stall_cnt++;
        end else if (rand_ready) begin
            dac_ready = 1'($urandom_range(0, 1));
        end else begin
            dac_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops on accepted beats, and held beats must not move
    initial begin
        bit           prev_hold = 0;
        logic [W-1:0] p_data, p_a, p_b;
        logic [2:0]   p_ch;
        logic         p_sub;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", dac_valid, 1);
                    check("hold_data", dac_data, p_data);
                    check("hold_ch", dac_ch, p_ch);
                    check("hold_sat_a", sat_a, p_a);
                    check("hold_sat_b", sat_b, p_b);
                    check("hold_sat_sub", sat_sub, p_sub);
                end
                if (dac_valid && dac_ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat_ch", dac_ch, e.ch);
                        check("beat_data", dac_data, e.data);
                    end
                end
                prev_hold = dac_valid && !dac_ready;
                p_data = dac_data;
                p_ch   = dac_ch;
                p_a    = sat_a;
                p_b    = sat_b;
                p_sub  = sat_sub;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        int done_cnt;
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) write_base(i, 14'h1000);
        sweep(1'b0, 14'h0040, 2 * N + 2, 1'b0, 1'b0, '0);
        first_signs = msign;
        sweep(1'b1, 14'h0040, 2 * N + 2, 1'b0, 1'b0, '0);

        // Clamp at both rails; each channel sees both directions across the two phases
        write_base(3, 14'h1FF0);
        write_base(5, 14'h0010);
        sweep(1'b0, 14'h0040, 2 * N + 2, 1'b0, 1'b0, '0);
        sweep(1'b1, 14'h0040, 2 * N + 2, 1'b0, 1'b0, '0);

        stall_en = 1; stall_ch = 2; stall_len = 5; stall_cnt = 0;
        sweep(1'b0, 14'h0040, 2 * N + 2 + 5, 1'b0, 1'b0, '0);
        stall_en = 0;

        sweep(1'b0, 14'h0123, 2 * N + 2, 1'b1, 1'b0, '0);
        sweep(1'b1, 14'h0123, 2 * N + 2, 1'b0, 1'b1, 14'h0ABC);

        rand_ready = 1;
        for (int it = 0; it < 6; it++) begin
            logic [W-1:0] stp;
            for (int i = 0; i < N; i++) write_base(i, W'($urandom));
            stp = W'($urandom);
            sweep(1'b0, stp, 0, 1'b0, 1'b0, '0);
            sweep(1'b1, stp, 0, 1'b0, 1'b0, '0);
        end
        rand_ready = 0;

        // Abort a sweep while channel 4 is waiting in SEND
        stall_en = 1; stall_ch = 4; stall_len = 1000; stall_cnt = 0;
        model_sweep(1'b0, 14'h0040);
        start = 1'b1; neg_phase = 1'b0; step = 14'h0040;
        tick();
        start = 1'b0;
        wait_cyc = 0;
        while (!(dac_valid && dac_ch == 3'd4) && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        check("reached_ch4_send", dac_valid && dac_ch == 3'd4, 1);
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        model_reset();
        stall_en = 0;
        rst = 1'b0;
        done_cnt = 0;
        repeat (30) begin
            tick();
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);

        for (int i = 0; i < N; i++) write_base(i, 14'h1000);
        sweep(1'b0, 14'h0040, 2 * N + 2, 1'b0, 1'b0, '0);
        check("signs_repeat_after_reset", sign_bits, first_signs);

        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
